// File: rtl/senone_normalise_pkg.sv
// senone_normalise shared types: score type, limits, FSM states
// and the 17-bit to 16-bit saturation helper.
package senone_normalise_pkg;

  typedef logic signed [15:0] num;

  localparam num NUM_MIN = 16'sh8000;
  localparam num NUM_MAX = 16'sh7fff;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_MAX,
    DRAIN
  } state_t;

  function automatic num sat17(input logic signed [16:0] v);
    if (v < -17'sd32768) begin
      return NUM_MIN;
    end else if (v > 17'sd32767) begin
      return NUM_MAX;
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/senone_normalise_if.sv
// senone_normalise bus: upstream score strobes, max-stage result,
// downstream valid/ready stream and status flags.
interface senone_normalise_if #(
  parameter int ADDR_W = 10
) ();
  import senone_normalise_pkg::*;

  logic              new_senone;
  logic              last_senone;
  num                current_score;
  num                best_score;
  logic              max_done;
  num                beam;
  logic              out_ready;
  logic              out_valid;
  num                out_score;
  logic              out_active;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              overflow;

  modport master (
    output new_senone, last_senone, current_score,
    output best_score, max_done, beam, out_ready,
    input  out_valid, out_score, out_active,
    input  out_index, out_last, busy, overflow
  );

  modport slave (
    input  new_senone, last_senone, current_score,
    input  best_score, max_done, beam, out_ready,
    output out_valid, out_score, out_active,
    output out_index, out_last, busy, overflow
  );

endinterface

// File: rtl/senone_normalise_buf.sv
// senone_buf: frame score store, one write port and one
// synchronous read port whose output holds when re_i is low.
module senone_buf
  import senone_normalise_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  num            wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output num            rdata_o
);

  num mem_q [DEPTH];

  // store incoming scores
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // registered read, frozen while the output stage stalls
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/senone_normalise.sv
// senone_normalise: buffer a frame, then stream score - best.
// Define SENONE_NORM_CLAMP_EN to force pruned scores to NUM_MIN.
module senone_normalise
  import senone_normalise_pkg::*;
#(
  parameter int MAX_SENONES = 1024,
  parameter int ADDR_W      = $clog2(MAX_SENONES)
) (
  input logic          clk,
  input logic          reset,
  senone_normalise_if.slave bus
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] MAXP = PW'(MAX_SENONES);

  state_t            state_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     count_q;
  num                best_q;
  logic              s1_valid_q;
  logic              s1_last_q;
  logic [ADDR_W-1:0] s1_idx_q;
  logic              out_valid_q;
  num                out_score_q;
  logic              out_active_q;
  logic [ADDR_W-1:0] out_index_q;
  logic              out_last_q;
  logic              busy_q;
  logic              overflow_q;

  num               rd_data;
  logic             full;
  logic             we;
  logic             advance;
  logic             issue;
  logic             hs_last;
  logic             bad_strobe;
  logic signed [16:0] diff;
  logic signed [16:0] neg_beam;
  logic             active_d;
  num               score_d;

  assign full    = (wr_ptr_q == MAXP);
  assign we      = bus.new_senone &&
                   (state_q == IDLE ||
                   (state_q == FILL && !full));
  assign advance = !out_valid_q || bus.out_ready;
  assign issue   = (state_q == DRAIN) &&
                   (rd_ptr_q < count_q) && advance;
  assign hs_last = out_valid_q && bus.out_ready &&
                   out_last_q;
  assign bad_strobe = bus.new_senone &&
                      ((state_q == FILL && full) ||
                       state_q == WAIT_MAX ||
                       state_q == DRAIN);

  senone_buf #(
    .DEPTH(MAX_SENONES),
    .AW   (ADDR_W)
  ) u_buf (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(wr_ptr_q[ADDR_W-1:0]),
    .wdata_i(bus.current_score),
    .re_i   (issue),
    .raddr_i(rd_ptr_q[ADDR_W-1:0]),
    .rdata_o(rd_data)
  );

  // normalise the buffered score and apply the beam test
  always_comb begin
    diff     = {rd_data[15], rd_data} - {best_q[15], best_q};
    neg_beam = -{bus.beam[15], bus.beam};
    active_d = (diff >= neg_beam);
    score_d  = sat17(diff);
`ifdef SENONE_NORM_CLAMP_EN
    if (!active_d) score_d = NUM_MIN;
`endif
  end

  // frame FSM, read pipeline and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      best_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_idx_q     <= '0;
      out_valid_q  <= 1'b0;
      out_score_q  <= '0;
      out_active_q <= 1'b0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (bad_strobe) overflow_q <= 1'b1;

      if (advance) begin
        s1_valid_q  <= issue;
        out_valid_q <= s1_valid_q;
        if (issue) begin
          s1_idx_q  <= rd_ptr_q[ADDR_W-1:0];
          s1_last_q <= (rd_ptr_q == count_q - 1'b1);
          rd_ptr_q  <= rd_ptr_q + 1'b1;
        end
        if (s1_valid_q) begin
          out_score_q  <= score_d;
          out_active_q <= active_d;
          out_index_q  <= s1_idx_q;
          out_last_q   <= s1_last_q;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (bus.new_senone) begin
            wr_ptr_q <= PW'(1);
            if (bus.last_senone) begin
              count_q <= PW'(1);
              state_q <= WAIT_MAX;
              busy_q  <= 1'b1;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FILL: begin
          if (bus.new_senone) begin
            if (!full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (bus.last_senone) begin
              count_q <= full ? wr_ptr_q
                              : wr_ptr_q + 1'b1;
              state_q <= WAIT_MAX;
              busy_q  <= 1'b1;
            end
          end
        end
        WAIT_MAX: begin
          if (bus.max_done) begin
            best_q   <= bus.best_score;
            rd_ptr_q <= '0;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs_last) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_score  = out_score_q;
  assign bus.out_active = out_active_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_senone_normalise.sv
// tb_senone_normalise: random frames against a plain-arithmetic
// model of score - best, saturation, beam test and frame length.
module tb_senone_normalise;
  import senone_normalise_pkg::*;

  localparam int MAXS = 8;
  localparam int AW   = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   frm[$];

  always #5 clk = ~clk;

  senone_normalise_if #(.ADDR_W(AW)) bus ();

  senone_normalise #(
    .MAX_SENONES(MAXS),
    .ADDR_W     (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int sc, input int best,
                                input int beam, output int es,
                                output bit ea);
    int d;
    d  = sc - best;
    ea = (d >= -beam);
    if (d < -32768) es = -32768;
    else if (d > 32767) es = 32767;
    else es = d;
`ifdef SENONE_NORM_CLAMP_EN
    if (!ea) es = -32768;
`endif
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic int frame_max();
    int m;
    m = -32768;
    foreach (frm[i]) if (frm[i] > m) m = frm[i];
    return m;
  endfunction

  task automatic rand_frame(input int n);
    frm = {};
    for (int i = 0; i < n; i++) frm.push_back(rnd16());
  endtask

  // mode 0: ready=1, 1: fixed pattern, 2: random ready
  task automatic run_frame(input int best, input int beam,
                           input int mode, input int poke,
                           input int stop_after);
    int cnt, got, first, want;
    int es[$];
    bit ea[$];
    int pat[6];
    pat = '{1, 0, 0, 1, 0, 1};
    cnt = (frm.size() < MAXS) ? frm.size() : MAXS;
    for (int i = 0; i < cnt; i++) begin
      int s;
      bit a;
      model(frm[i], best, beam, s, a);
      es.push_back(s);
      ea.push_back(a);
    end
    bus.beam = 16'(beam);
    for (int i = 0; i < frm.size(); i++) begin
      bus.new_senone    = 1'b1;
      bus.current_score = 16'(frm[i]);
      bus.last_senone   = (i == frm.size() - 1);
      @(posedge clk); #1;
    end
    bus.new_senone  = 1'b0;
    bus.last_senone = 1'b0;
    bus.max_done    = 1'b1;
    bus.best_score  = 16'(best);
    @(posedge clk); #1;
    bus.max_done   = 1'b0;
    bus.best_score = 16'($urandom);
    got   = 0;
    first = -1;
    for (int k = 0; k < 300 && got < cnt && got < stop_after;
         k++) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = pat[k % 6][0];
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      bus.new_senone = (k == poke);
      @(negedge clk);
      if (bus.out_valid) begin
        if (first < 0) first = k;
        check("score", int'(bus.out_score), es[got]);
        check("active", int'(bus.out_active), int'(ea[got]));
        check("index", int'(bus.out_index), got);
        check("last", int'(bus.out_last), int'(got == cnt - 1));
        if (bus.out_ready) got++;
      end
      @(posedge clk); #1;
    end
    bus.new_senone = 1'b0;
    want = (stop_after < cnt) ? stop_after : cnt;
    check("latency", first, 2);
    check("handshakes", got, want);
  endtask

  task automatic post_idle();
    check("end_valid", int'(bus.out_valid), 0);
    check("end_busy", int'(bus.busy), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset             = 1'b1;
    bus.new_senone    = 1'b0;
    bus.last_senone   = 1'b0;
    bus.current_score = '0;
    bus.best_score    = '0;
    bus.max_done      = 1'b0;
    bus.beam          = 16'd1000;
    bus.out_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_score", int'(bus.out_score), 0);
    check("rst_active", int'(bus.out_active), 0);
    check("rst_index", int'(bus.out_index), 0);
    check("rst_last", int'(bus.out_last), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("idle_valid", int'(bus.out_valid), 0);
    end

    frm = '{-100, 50, -3000, 20};
    run_frame(50, 1000, 0, -1, 99);
    post_idle();

    frm = '{-32768};
    run_frame(32767, 1000, 0, -1, 99);
    post_idle();

    rand_frame(8);
    run_frame(frame_max(), 2000, 1, -1, 99);
    post_idle();

    for (int f = 0; f < 20; f++) begin
      int best;
      rand_frame(int'($urandom_range(1, MAXS)));
      best = ($urandom_range(0, 3) == 0) ? rnd16() : frame_max();
      run_frame(best, int'($urandom_range(1, 32767)),
                int'($urandom_range(0, 2)), -1, 99);
      post_idle();
    end
    check("no_ovf", int'(bus.overflow), 0);

    rand_frame(MAXS + 2);
    run_frame(frame_max(), 5000, 2, -1, 99);
    post_idle();
    check("ovf_full", int'(bus.overflow), 1);

    pulse_reset();
    check("ovf_cleared", int'(bus.overflow), 0);
    rand_frame(5);
    run_frame(frame_max(), 3000, 2, 3, 99);
    check("ovf_drain", int'(bus.overflow), 1);

    pulse_reset();
    rand_frame(5);
    run_frame(frame_max(), 3000, 0, -1, 2);
    check("pre_rst_valid", int'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    check("async_valid", int'(bus.out_valid), 0);
    check("async_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    frm = '{7};
    run_frame(7, 1000, 0, -1, 99);
    post_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
